// File: rtl/sobel_pkg.sv
// sobel_pkg: shared width offsets, mode encodings and border mask for the Sobel stream filter
package sobel_pkg;

    // Gradient width is DW+GW_EXT, magnitude width is DW+MW_EXT
    localparam int GW_EXT = 3;
    localparam int MW_EXT = 4;

    localparam logic MODE_BIN = 1'b0;
    localparam logic MODE_MAG = 1'b1;

    // Pixels in the first two rows or columns have an incomplete window
    function automatic logic border_mask(input int unsigned r, input int unsigned c);
        return (r < 2) || (c < 2);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: two stacked row buffers sharing one address, read-before-write
module sobel_line_buf #(
    parameter int DW    = 8,
    parameter int IMG_W = 640
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(IMG_W)-1:0] addr,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            row1,
    output logic [DW-1:0]            row2
);

    logic [2*DW-1:0] mem [IMG_W];

    assign {row2, row1} = mem[addr];

    // Age the column by one row: old row1 becomes row2, the new pixel becomes row1
    always_ff @(posedge clk)
        if (we)
            mem[addr] <= {row1, din};

endmodule

// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter: 3x3 Sobel edge filter on a sop/eop framed raster stream, latency 3
module sobel_stream_filter #(
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    input  logic          din_sop,
    input  logic          din_eop,
    input  logic [DW+3:0] thr,
    input  logic          mode,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          dout_sop,
    output logic          dout_eop
);

    import sobel_pkg::*;

    localparam int GW = DW + GW_EXT;
    localparam int MW = DW + MW_EXT;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]          col, pcol;
    logic [RW-1:0]          row, prow;
    logic                   col_last;
    logic [DW-1:0]          lb1, lb2;
    logic [DW-1:0]          win [3][3];
    logic                   v1, sop1, eop1, bd1;
    logic signed [GW-1:0]   gx, gy, gx_n, gy_n;
    logic                   v2, sop2, eop2, bd2;
    logic [GW-1:0]          ax, ay;
    logic [MW-1:0]          mag;
    logic [DW-1:0]          res;

    function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] v);
        return $signed(GW'(v));
    endfunction

    // sop pins the current pixel to (0,0) regardless of where the counters were
    assign pcol     = din_sop ? '0 : col;
    assign prow     = din_sop ? '0 : row;
    assign col_last = pcol == CW'(IMG_W - 1);

    sobel_line_buf #(.DW(DW), .IMG_W(IMG_W)) u_lb (
        .clk  (clk),
        .we   (din_vld),
        .addr (pcol),
        .din  (din),
        .row1 (lb1),
        .row2 (lb2)
    );

    // Raster position: col wraps into row, row saturates when eop never comes
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (din_vld) begin
            col <= col_last ? '0 : pcol + 1'b1;
            row <= (!col_last || prow == RW'(IMG_H - 1)) ? prow : prow + 1'b1;
        end

    // S1: shift the 3x3 window on valid beats and capture the border flag
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
            v1   <= 1'b0;
            sop1 <= 1'b0;
            eop1 <= 1'b0;
            bd1  <= 1'b0;
        end else begin
            v1   <= din_vld;
            sop1 <= din_vld & din_sop;
            eop1 <= din_vld & din_eop;
            if (din_vld) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb2;
                win[1][2] <= lb1;
                win[2][2] <= din;
                bd1       <= border_mask(32'(prow), 32'(pcol));
            end
        end

    // Horizontal and vertical Sobel kernels on the window, zero-extended to signed
    always_comb begin
        gx_n = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
             - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
        gy_n = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
             - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
    end

    // S2: register gradients and forward framing/border flags
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            gx   <= '0;
            gy   <= '0;
            v2   <= 1'b0;
            sop2 <= 1'b0;
            eop2 <= 1'b0;
            bd2  <= 1'b0;
        end else begin
            gx   <= gx_n;
            gy   <= gy_n;
            v2   <= v1;
            sop2 <= sop1;
            eop2 <= eop1;
            bd2  <= bd1;
        end

    // L1 magnitude, then threshold or saturate; border pixels are forced to 0
    always_comb begin
        ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag = MW'(ax) + MW'(ay);
        res = bd2 ? '0
            : mode == MODE_MAG ? (mag > MW'({DW{1'b1}}) ? '1 : mag[DW-1:0])
            : (mag >= thr ? '1 : '0);
    end

    // S3: output register; dout keeps its last value across gaps
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else begin
            if (v2)
                dout <= res;
            dout_vld <= v2;
            dout_sop <= sop2;
            dout_eop <= eop2;
        end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb_sobel_stream_filter: scoreboard bench for the Sobel stream filter on an 8x6 image
module tb_sobel_stream_filter;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = '0;
    logic        din_vld = 1'b0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic [11:0] thr = '0;
    logic        mode = 1'b0;
    logic [7:0]  dout;
    logic        dout_vld, dout_sop, dout_eop;

    typedef struct {
        int d;
        int s;
        int e;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_d = 0;
    int   img [H][W];
    int   mr = 0;
    int   mc = 0;

    sobel_stream_filter #(.DW(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .thr      (thr),
        .mode     (mode),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pix(input int pat, input int r, input int c);
        if (pat == 0) return 'h55;
        if (pat == 1) return c >= 4 ? 255 : 0;
        return (r == 2 && c == 2) ? 255 : 0;
    endfunction

    // Reference: Sobel on the stored image around (r-1, c-1)
    function automatic int expect_px(input int r, input int c, input int md, input int th);
        int p [3][3];
        int gx, gy, m;
        if (r < 2 || c < 2) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[r-2+i][c-2+j];
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (md != 0) return m > 255 ? 255 : m;
        return m >= th ? 255 : 0;
    endfunction

    task automatic beat(input int v, input bit s, input bit e);
        @(posedge clk);
        #1;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = v;
        q.push_back('{d: expect_px(mr, mc, int'(mode), int'(thr)), s: int'(s), e: int'(e), cyc: cyc});
        din     = 8'(v);
        din_vld = 1'b1;
        din_sop = s;
        din_eop = e;
        if (mc == W - 1) begin
            mc = 0;
            if (mr < H - 1) mr++;
        end else
            mc++;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
    endtask

    task automatic frame(input int pat, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps)
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) idle();
            beat(pix(pat, i / W, i % W), i == 0, i == W*H - 1);
        end
        idle();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        check("drain", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check("hold_dout", int'(dout), last_d);
        check("idle_vld", int'(dout_vld), 0);
    endtask

    always @(negedge clk)
        if (rst_n && dout_vld) begin
            exp_t x;
            if (q.size() == 0)
                check("spurious_vld", int'(dout_vld), 0);
            else begin
                x = q.pop_front();
                check("dout", int'(dout), x.d);
                check("sop", int'(dout_sop), x.s);
                check("eop", int'(dout_eop), x.e);
                check("latency", cyc - x.cyc, 3);
                last_d = int'(dout);
            end
        end

    initial begin
        #12;
        check("rst_dout", int'(dout), 0);
        check("rst_vld", int'(dout_vld), 0);
        check("rst_sop", int'(dout_sop), 0);
        check("rst_eop", int'(dout_eop), 0);
        rst_n = 1'b1;

        mode = 1'b0; thr = 12'd1;
        frame(0, W*H, 1'b0); drain();

        mode = 1'b1;
        frame(1, W*H, 1'b0); drain();

        mode = 1'b0; thr = 12'd1020;
        frame(1, W*H, 1'b0); drain();
        thr = 12'd1021;
        frame(1, W*H, 1'b0); drain();

        mode = 1'b1;
        frame(2, W*H, 1'b0); drain();

        frame(1, W*H, 1'b1); drain();

        beat(77, 1'b1, 1'b1); idle(); drain();

        frame(1, 3*W + 4, 1'b0);
        frame(1, W*H, 1'b0); drain();

        for (int i = 0; i < 20; i++) beat(pix(2, i / W, i % W), i == 0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        #1;
        check("midrst_dout", int'(dout), 0);
        check("midrst_vld", int'(dout_vld), 0);
        check("midrst_sop", int'(dout_sop), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_d = 0;
        frame(2, W*H, 1'b0); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
